// File: rtl/bht_predictor.sv
// Branch history table: 2^INDEX_W two-bit saturating counters indexed by PC[INDEX_W+1:2], plus a misprediction counter.
// Ports: Clk/Clrn clock and async active-low reset; En global update enable; Pc_f -> Pred_state/Pred_taken fetch lookup;
//        Upd_valid/Upd_pc/Upd_taken/Upd_pred resolved-branch update; Miss_cnt saturating misprediction count.
// Latency: zero-cycle combinational prediction, updates land on the rising edge; no backpressure (En=0 freezes all state).
// Optional build macro BHT_BYPASS_EN: on a fetch/update index collision, forward the post-update counter to Pred_state.

module bht_predictor #(
    parameter int PC_W    = 32,
    parameter int INDEX_W = 4
) (
    input  logic            Clk,
    input  logic            Clrn,
    input  logic            En,
    input  logic [PC_W-1:0] Pc_f,
    output logic [1:0]      Pred_state,
    output logic            Pred_taken,
    input  logic            Upd_valid,
    input  logic [PC_W-1:0] Upd_pc,
    input  logic            Upd_taken,
    input  logic            Upd_pred,
    output logic [15:0]     Miss_cnt
);

    localparam int ENTRIES = 1 << INDEX_W;

    logic [1:0]         table_q [ENTRIES];
    logic [15:0]        miss_q;
    logic [INDEX_W-1:0] fetch_idx;
    logic [INDEX_W-1:0] upd_idx;
    logic               upd_fire;
    logic [1:0]         upd_cur;
    logic [1:0]         upd_next;

    // Word-aligned PCs: the two low bits and everything above the index are untagged.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{Pc_f[PC_W-1:INDEX_W+2], Pc_f[1:0],
                              Upd_pc[PC_W-1:INDEX_W+2], Upd_pc[1:0]};

    assign fetch_idx = Pc_f[INDEX_W+1:2];
    assign upd_idx   = Upd_pc[INDEX_W+1:2];
    assign upd_fire  = Upd_valid & En;

    // Saturating step of the counter being trained.
    always_comb begin
        upd_cur  = table_q[upd_idx];
        upd_next = upd_cur;
        if (Upd_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'b01;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'b01;
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
            miss_q <= '0;
        end else if (upd_fire) begin
            table_q[upd_idx] <= upd_next;
            if ((Upd_taken != Upd_pred) && (miss_q != 16'hFFFF)) begin
                miss_q <= miss_q + 16'd1;
            end
        end
    end

`ifdef BHT_BYPASS_EN
    // Forward the in-flight update so fetch sees the value the table will hold after this edge.
    always_comb begin
        Pred_state = table_q[fetch_idx];
        if (upd_fire && (upd_idx == fetch_idx)) begin
            Pred_state = upd_next;
        end
    end
`else
    // Stored value only; a colliding update becomes visible after the edge.
    assign Pred_state = table_q[fetch_idx];
`endif

    assign Pred_taken = Pred_state[1];
    assign Miss_cnt   = miss_q;

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed vector table, hand sequences for bypass,
// reset and counter saturation, then randomized traffic against an arithmetic reference model.
module tb_bht_predictor;

    localparam int PC_W    = 32;
    localparam int INDEX_W = 4;
    localparam int N       = 16;
`ifdef BHT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        En;
    logic [31:0] Pc_f;
    logic [1:0]  Pred_state;
    logic        Pred_taken;
    logic        Upd_valid;
    logic [31:0] Upd_pc;
    logic        Upd_taken;
    logic        Upd_pred;
    logic [15:0] Miss_cnt;

    int checks   = 0;
    int failures = 0;
    int cnt [N];
    int misses;

    typedef struct {
        bit          en;
        bit          valid;
        logic [31:0] upd_pc;
        bit          taken;
        bit          pred;
        logic [31:0] pc_f;
        logic [1:0]  exp_state;
        logic [15:0] exp_miss;
    } vec_t;

    vec_t vecs [13];

    bht_predictor #(.PC_W(PC_W), .INDEX_W(INDEX_W)) dut (
        .Clk       (Clk),
        .Clrn      (Clrn),
        .En        (En),
        .Pc_f      (Pc_f),
        .Pred_state(Pred_state),
        .Pred_taken(Pred_taken),
        .Upd_valid (Upd_valid),
        .Upd_pc    (Upd_pc),
        .Upd_taken (Upd_taken),
        .Upd_pred  (Upd_pred),
        .Miss_cnt  (Miss_cnt)
    );

    always #20 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit en, bit valid, logic [31:0] upc, bit t, bit p,
                                logic [31:0] pcf, logic [1:0] st, logic [15:0] ms);
        vec_t v;
        v.en = en; v.valid = valid; v.upd_pc = upc; v.taken = t; v.pred = p;
        v.pc_f = pcf; v.exp_state = st; v.exp_miss = ms;
        return v;
    endfunction

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic int step(int c, bit t);
        if (t) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) cnt[i] = 1;
        misses = 0;
    endtask

    task automatic model_edge(bit en, bit valid, logic [31:0] pc, bit t, bit p);
        if (en && valid) begin
            cnt[idx_of(pc)] = step(cnt[idx_of(pc)], t);
            if (t != p && misses < 65535) misses++;
        end
    endtask

    task automatic drive(bit en, bit valid, logic [31:0] upc, bit t, bit p, logic [31:0] pcf);
        En = en; Upd_valid = valid; Upd_pc = upc; Upd_taken = t; Upd_pred = p; Pc_f = pcf;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Clrn = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        check("rst_pred_state", {30'd0, Pred_state}, 32'd1);
        check("rst_miss", {16'd0, Miss_cnt}, 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Clrn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0] exp_pre;
        int         fi;
        int         ui;

        vecs[0]  = mk(1, 1, 32'h08, 1, 0, 32'h08, 2'd2, 16'd1);
        vecs[1]  = mk(1, 1, 32'h08, 1, 0, 32'h08, 2'd3, 16'd2);
        vecs[2]  = mk(1, 1, 32'h08, 1, 0, 32'h08, 2'd3, 16'd3);
        vecs[3]  = mk(1, 0, 32'h00, 0, 0, 32'h48, 2'd3, 16'd3);
        vecs[4]  = mk(1, 1, 32'h08, 0, 0, 32'h08, 2'd2, 16'd3);
        vecs[5]  = mk(1, 1, 32'h08, 0, 0, 32'h08, 2'd1, 16'd3);
        vecs[6]  = mk(1, 1, 32'h08, 0, 0, 32'h08, 2'd0, 16'd3);
        vecs[7]  = mk(1, 1, 32'h08, 0, 0, 32'h08, 2'd0, 16'd3);
        vecs[8]  = mk(1, 1, 32'h08, 0, 0, 32'h08, 2'd0, 16'd3);
        vecs[9]  = mk(1, 0, 32'h00, 0, 0, 32'h0C, 2'd1, 16'd3);
        vecs[10] = mk(0, 1, 32'h10, 1, 0, 32'h10, 2'd1, 16'd3);
        vecs[11] = mk(0, 1, 32'h10, 1, 0, 32'h10, 2'd1, 16'd3);
        vecs[12] = mk(1, 1, 32'h10, 1, 0, 32'h10, 2'd2, 16'd4);

        Clrn = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        do_reset();

        // Post-reset sweep: every entry weak-NT.
        for (int pc = 0; pc <= 32'h3C; pc += 4) begin
            Pc_f = 32'(pc);
            #1;
            check("sweep_state", {30'd0, Pred_state}, 32'd1);
            check("sweep_taken", {31'd0, Pred_taken}, 32'd0);
        end
        check("sweep_miss", {16'd0, Miss_cnt}, 32'd0);

        // Directed table: expected state/miss after each edge.
        for (int i = 0; i < 13; i++) begin
            @(negedge Clk);
            drive(vecs[i].en, vecs[i].valid, vecs[i].upd_pc, vecs[i].taken, vecs[i].pred, vecs[i].pc_f);
            @(posedge Clk);
            #1;
            Upd_valid = 1'b0;
            En        = 1'b1;
            #1;
            check($sformatf("vec%0d_state", i), {30'd0, Pred_state}, {30'd0, vecs[i].exp_state});
            check($sformatf("vec%0d_taken", i), {31'd0, Pred_taken}, {31'd0, vecs[i].exp_state[1]});
            check($sformatf("vec%0d_miss", i), {16'd0, Miss_cnt}, {16'd0, vecs[i].exp_miss});
        end

        // Alias check and neighbour entry after the entry-2 training.
        Pc_f = 32'h48;
        #1;
        check("alias_48", {30'd0, Pred_state}, 32'd0);

        // Same-cycle collision at entry 3 (weak-NT, untouched so far).
        @(negedge Clk);
        drive(1'b1, 1'b1, 32'h0C, 1'b1, 1'b0, 32'h0C);
        #1;
        check("collide_pre", {30'd0, Pred_state}, BYP ? 32'd2 : 32'd1);
        @(posedge Clk);
        #1;
        Upd_valid = 1'b0;
        #1;
        check("collide_post", {30'd0, Pred_state}, 32'd2);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] upc;
            logic [31:0] pcf;
            bit          en;
            bit          vl;
            bit          t;
            bit          p;
            @(negedge Clk);
            upc = $urandom;
            pcf = ($urandom_range(0, 3) == 0) ? upc : $urandom;
            en  = ($urandom_range(0, 4) != 0);
            vl  = ($urandom_range(0, 3) != 0);
            t   = 1'($urandom);
            p   = 1'($urandom);
            drive(en, vl, upc, t, p, pcf);
            #1;
            fi = idx_of(pcf);
            ui = idx_of(upc);
            exp_pre = 2'(cnt[fi]);
            if (BYP && en && vl && fi == ui) exp_pre = 2'(step(cnt[ui], t));
            check("rand_state", {30'd0, Pred_state}, {30'd0, exp_pre});
            check("rand_taken", {31'd0, Pred_taken}, {31'd0, exp_pre[1]});
            @(posedge Clk);
            model_edge(en, vl, upc, t, p);
            #1;
            check("rand_miss", {16'd0, Miss_cnt}, 32'(misses));
        end

        // Miss counter saturation.
        do_reset();
        @(negedge Clk);
        drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h20);
        repeat (65534) @(posedge Clk);
        #1;
        Upd_valid = 1'b0;
        #1;
        check("miss_fffe", {16'd0, Miss_cnt}, 32'h0000FFFE);
        @(negedge Clk);
        Upd_valid = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        check("miss_sat", {16'd0, Miss_cnt}, 32'h0000FFFF);
        check("sat_entry", {30'd0, Pred_state}, 32'd3);

        // Mid-cycle async reset with an update still presented.
        #4;
        Clrn = 1'b0;
        #1;
        check("arst_miss", {16'd0, Miss_cnt}, 32'd0);
        for (int pc = 0; pc <= 32'h3C; pc += 4) begin
            Pc_f = 32'(pc);
            #1;
            check("arst_entry", {30'd0, Pred_state}, 32'd1);
        end
        Pc_f = 32'h20;
        @(posedge Clk);
        #1;
        check("rst_discard_entry", {30'd0, Pred_state}, 32'd1);
        check("rst_discard_miss", {16'd0, Miss_cnt}, 32'd0);
        @(negedge Clk);
        Clrn = 1'b1;
        @(posedge Clk);
        #1;
        Upd_valid = 1'b0;
        #1;
        check("first_edge_entry", {30'd0, Pred_state}, 32'd2);
        check("first_edge_miss", {16'd0, Miss_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, width of all PC inputs.
REQ-002 The block SHALL have parameter INDEX_W, default 4, table index width (2^INDEX_W entries).
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port Clrn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port En, input, 1 bit: global update enable; low during a pipeline stall.
REQ-006 The block SHALL have port Pc_f, input, PC_W bits: the fetch-stage PC to predict for.
REQ-007 The block SHALL have port Pred_state, output, 2 bits: the counter value for Pc_f, consumed by the IF/ID 2-bit pipeline register.
REQ-008 The block SHALL have port Pred_taken, output, 1 bit: the predicted direction, equal to Pred_state[1].
REQ-009 The block SHALL have port Upd_valid, input, 1 bit: a resolved conditional branch is presented this cycle.
REQ-010 The block SHALL have port Upd_pc, input, PC_W bits: the PC of the resolved branch.
REQ-011 The block SHALL have port Upd_taken, input, 1 bit: the actual branch outcome.
REQ-012 The block SHALL have port Upd_pred, input, 1 bit: the prediction made at fetch, carried down the pipeline.
REQ-013 The block SHALL have port Miss_cnt, output, 16 bits: the count of mispredictions.

Function
REQ-014 Index SHALL be PC[INDEX_W+1:2] for both the fetch and update paths; no tags (aliasing permitted).
REQ-015 Each entry SHALL be a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 Pred_state SHALL be a combinational read of the entry indexed by Pc_f (zero-cycle latency).
REQ-017 On a rising edge with Upd_valid=1, En=1 and Upd_taken=1, the indexed entry SHALL increment, saturating at 11.
REQ-018 On a rising edge with Upd_valid=1, En=1 and Upd_taken=0, the indexed entry SHALL decrement, saturating at 00.
REQ-019 Only the indexed entry SHALL change per cycle; all other entries hold.
REQ-020 On a rising edge with Upd_valid=1, En=1 and Upd_taken!=Upd_pred, Miss_cnt SHALL increment by 1, saturating at 16'hFFFF (no wrap).
REQ-021 With En=0, no entry or Miss_cnt change SHALL occur, regardless of Upd_valid; Pred_state SHALL still be driven.
REQ-022 With Upd_valid=0, Upd_pc, Upd_taken and Upd_pred SHALL be ignored (X-tolerant).
REQ-023 When fetch and update indices collide in the same cycle, the behaviour SHALL be per REQ-028/029.

Reset
REQ-024 Clrn=0 SHALL asynchronously set every table entry to 01 (weak-NT) and Miss_cnt to 0.
REQ-025 Pred_state SHALL therefore read 01 and Pred_taken 0 for any Pc_f while in reset and immediately after.
REQ-026 An update coinciding with the rising edge while Clrn=0 SHALL be discarded; reset SHALL take priority.
REQ-027 Reset deassertion mid-operation SHALL require no initialisation cycles; the first edge after release may update.

Configuration
REQ-028 With macro BHT_BYPASS_EN defined, on an index collision with an enabled valid update, Pred_state SHALL show the post-update (next) counter value combinationally.
REQ-029 With BHT_BYPASS_EN undefined, on a collision Pred_state SHALL show the stored (pre-update) value; the table update is identical in both builds.

Verification (INDEX_W=4)
REQ-030 Release reset, sweep Pc_f over 0x00..0x3C -> Pred_state=01, Pred_taken=0, Miss_cnt=0 for all.
REQ-031 Three updates at Upd_pc=0x08, taken=1, pred=0, En=1 -> entry 2 goes 10, 11, 11; Miss_cnt=3; Pc_f=0x48 (alias) also reads 11.
REQ-032 From 11, two not-taken updates, then three more at entry 2 -> 10, 01, 00, 00, 00; entry 3 stays 01.
REQ-033 Updates with En=0 at Upd_pc=0x10 -> entry 4 stays 01 and Miss_cnt unchanged; repeat with En=1 -> changes.
REQ-034 Pc_f=Upd_pc=0x0C, entry 01, taken=1 -> Pred_state=10 in the same cycle with BHT_BYPASS_EN, 01 without; 10 after the edge in both builds.
REQ-035 Force Miss_cnt to 0xFFFE via 0xFFFE misses, then 2 more misses -> 0xFFFF held; assert Clrn mid-cycle -> Miss_cnt=0 and all entries 01 before the next edge.
